// File: rtl/dmem_bus_master.sv
// Processor-side initiator for the external data-memory bus: one load/store at a time,
// alignment check, wait-state timeout, load extension and store lane placement.
module dmem_bus_master #(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_uns,
    input  logic [BIT_WIDTH-1:0] req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [BIT_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 stall,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    output logic [BIT_WIDTH-1:0] ddt_o,
    output logic                 ddt_oe,
    input  logic [BIT_WIDTH-1:0] ddt_i,
    input  logic                 ACKD_n
);

    typedef enum logic {S_IDLE, S_BUS} state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Counter only needs to reach TIMEOUT-1; with TIMEOUT==0 it just saturates.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          uns_q;
    logic          handshake;

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_WORD: return a != 2'b00;
            SZ_HALF: return a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BIT_WIDTH-1:0] store_lane(input logic [1:0] sz,
                                                        input logic [BIT_WIDTH-1:0] d);
        case (sz)
            SZ_WORD: return d;
            SZ_HALF: return {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
            default: return {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
        endcase
    endfunction

    function automatic logic [BIT_WIDTH-1:0] load_ext(input logic [1:0] sz, input logic uns,
                                                      input logic [BIT_WIDTH-1:0] d);
        case (sz)
            SZ_WORD: return d;
            SZ_HALF: return {{(BIT_WIDTH-16){~uns & d[15]}}, d[15:0]};
            default: return {{(BIT_WIDTH-8){~uns & d[7]}}, d[7:0]};
        endcase
    endfunction

    assign req_ready = (state == S_IDLE);
    assign handshake = req_valid & req_ready;
    assign stall     = (state != S_IDLE) | handshake;
    assign ddt_oe    = MREQ & WRITE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            uns_q     <= 1'b0;
            MREQ      <= 1'b0;
            WRITE     <= 1'b0;
            SIZE      <= 2'b00;
            DAD       <= '0;
            ddt_o     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        cnt <= '0;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            DAD   <= req_addr;
                            WRITE <= req_write;
                            SIZE  <= req_size;
                            ddt_o <= req_write ? store_lane(req_size, req_wdata) : '0;
                            uns_q <= req_uns;
                            MREQ  <= 1'b1;
                            state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    if (!ACKD_n) begin
                        MREQ      <= 1'b0;
                        state     <= S_IDLE;
                        rsp_valid <= 1'b1;
                        if (!WRITE)
                            rsp_rdata <= load_ext(SIZE, uns_q, ddt_i);
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        MREQ      <= 1'b0;
                        state     <= S_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
